wallace_mul16_seq: RTL



---
 rtl/wallace_mul16_seq_if.sv | 22 ++
 rtl/wallace_mul16_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/wallace_mul16_seq_if.sv
// Operand/result handshake bundle for the sequential 16x16 multiplier.
// The master side supplies operands and accepts results; the slave side is the multiplier.
interface wallace_mul16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/wallace_mul16_seq.sv
// 16x16 unsigned multiplier that reuses one 8x8 Wallace tree over four passes,
// accumulating shifted partial products before presenting the 32-bit result.
module wallace_mul16_seq (
  input  logic                      clk,
  input  logic                      rst,
  wallace_mul16_seq_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      state_q;
  logic [1:0]  pass_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [31:0] acc_q;

  logic [8:1]  tree_a;
  logic [8:1]  tree_b;
  logic [16:1] tree_p;
  logic [31:0] term;

  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // 8 rows -> 6 -> 4 -> 3 -> 2 via 3:2 compressors, then one carry-propagate add.
  // 16 bits suffice: the true product fits, so truncated carries are always zero.
  function automatic logic [15:0] wallace8x8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] pp [8];
    logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    for (int i = 0; i < 8; i++) begin
      pp[i] = y[i] ? (16'(x) << i) : 16'h0000;
    end
    s0 = csa_s(pp[0], pp[1], pp[2]);  c0 = csa_c(pp[0], pp[1], pp[2]);
    s1 = csa_s(pp[3], pp[4], pp[5]);  c1 = csa_c(pp[3], pp[4], pp[5]);
    s2 = csa_s(s0, c0, s1);           c2 = csa_c(s0, c0, s1);
    s3 = csa_s(c1, pp[6], pp[7]);     c3 = csa_c(c1, pp[6], pp[7]);
    s4 = csa_s(s2, c2, s3);           c4 = csa_c(s2, c2, s3);
    s5 = csa_s(s4, c4, c3);           c5 = csa_c(s4, c4, c3);
    return s5 + c5;
  endfunction

  always_comb begin
    tree_a = a_q[7:0];
    tree_b = b_q[7:0];
    unique case (pass_q)
      2'd0: begin tree_a = a_q[7:0];  tree_b = b_q[7:0];  end
      2'd1: begin tree_a = a_q[15:8]; tree_b = b_q[7:0];  end
      2'd2: begin tree_a = a_q[7:0];  tree_b = b_q[15:8]; end
      2'd3: begin tree_a = a_q[15:8]; tree_b = b_q[15:8]; end
    endcase
  end

  assign tree_p = wallace8x8(tree_a, tree_b);

  always_comb begin
    term = {16'h0000, tree_p};
    unique case (pass_q)
      2'd0:       term = {16'h0000, tree_p};
      2'd1, 2'd2: term = {8'h00, tree_p, 8'h00};
      2'd3:       term = {tree_p, 16'h0000};
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.prod      = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pass_q  <= 2'd0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      acc_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc_q   <= 32'h0000_0000;
            pass_q  <= 2'd0;
            state_q <= StMul;
          end
        end
        StMul: begin
          acc_q  <= acc_q + term;
          pass_q <= pass_q + 2'd1;
          if (pass_q == 2'd3) state_q <= StDone;
        end
        StDone: begin
          // Consume and re-accept share one edge so back-to-back ops have no bubble.
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              a_q     <= bus.a;
              b_q     <= bus.b;
              acc_q   <= 32'h0000_0000;
              pass_q  <= 2'd0;
              state_q <= StMul;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
